// File: rtl/free_list.sv
// Physical-register free list for a renaming core: circular buffer of free
// preg indices with a speculative head and a committed retire_head for flush recovery.
module free_list #(
  parameter int NUM_REGS = 64,
  localparam int PW = $clog2(NUM_REGS),
  localparam int DEPTH = NUM_REGS - 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_valid,
  output logic [PW-1:0] alloc_preg,
  input  logic          free_req,
  input  logic [PW-1:0] free_preg,
  input  logic          commit_alloc,
  input  logic          flush,
  output logic          empty,
  output logic          full,
  output logic [PW:0]   count,
  output logic          overflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointer increment that wraps at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    if (p == AW'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + AW'(1);
    end
    return n;
  endfunction

  logic [PW-1:0] mem_r [DEPTH];
  logic [AW-1:0] head_r, tail_r, retire_head_r;
  logic [PW:0]   count_r, retire_count_r;
  logic          empty_r, full_r, err_r;

  logic          acc_alloc_s, free_try_s, acc_free_s, acc_commit_s, err_s;
  logic [AW-1:0] head_nxt_s, tail_nxt_s, retire_head_nxt_s;
  logic [PW:0]   count_nxt_s, retire_count_nxt_s;

  // Accept/reject decisions and next-state values; a flush restores the
  // committed view after this cycle's commit and free have been folded in.
  always_comb begin
    acc_alloc_s  = alloc_req && !empty_r && !flush;
    free_try_s   = free_req && (free_preg != '0);
    acc_free_s   = free_try_s && !full_r;
    acc_commit_s = commit_alloc && (retire_count_r != '0);
    err_s        = (free_try_s && full_r) || (commit_alloc && (retire_count_r == '0));

    retire_count_nxt_s = retire_count_r + {{PW{1'b0}}, acc_free_s}
                                        - {{PW{1'b0}}, acc_commit_s};
    retire_head_nxt_s  = acc_commit_s ? next_ptr(retire_head_r) : retire_head_r;
    tail_nxt_s         = acc_free_s ? next_ptr(tail_r) : tail_r;

    if (flush) begin
      head_nxt_s  = retire_head_nxt_s;
      count_nxt_s = retire_count_nxt_s;
    end else begin
      head_nxt_s  = acc_alloc_s ? next_ptr(head_r) : head_r;
      count_nxt_s = count_r + {{PW{1'b0}}, acc_free_s}
                            - {{PW{1'b0}}, acc_alloc_s};
    end
  end

  // State update; reset reloads the buffer with pregs 32..NUM_REGS-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= PW'(32 + i);
      end
      head_r         <= '0;
      tail_r         <= '0;
      retire_head_r  <= '0;
      count_r        <= (PW+1)'(DEPTH);
      retire_count_r <= (PW+1)'(DEPTH);
      empty_r        <= 1'b0;
      full_r         <= 1'b1;
      err_r          <= 1'b0;
    end else begin
      if (acc_free_s) begin
        mem_r[tail_r] <= free_preg;
      end
      head_r         <= head_nxt_s;
      tail_r         <= tail_nxt_s;
      retire_head_r  <= retire_head_nxt_s;
      count_r        <= count_nxt_s;
      retire_count_r <= retire_count_nxt_s;
      empty_r        <= (count_nxt_s == '0);
      full_r         <= (count_nxt_s == (PW+1)'(DEPTH));
      err_r          <= err_r || err_s;
    end
  end

  // A freed preg lands at tail, so it cannot reach this read port before the next cycle.
  assign alloc_preg   = mem_r[head_r];
  assign alloc_valid  = !empty_r;
  assign empty        = empty_r;
  assign full         = full_r;
  assign count        = count_r;
  assign overflow_err = err_r;

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_REGS, default 64 (from rv32i_types); the total number of physical registers. PW = $clog2(NUM_REGS).
REQ-002 SHALL have derived parameter DEPTH = NUM_REGS - 32; the number of free-list entries.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-low reset.
REQ-005 SHALL have port alloc_req, input, 1 bit; the rename stage consumes the head entry (architectural rd != x0).
REQ-006 SHALL have port alloc_valid, output, 1 bit; high when the list is non-empty and alloc_preg is meaningful.
REQ-007 SHALL have port alloc_preg, output, PW bits; the physical register index at the head, fed to rename as physical_rd.
REQ-008 SHALL have port free_req, input, 1 bit; the ROB commit returns the previous mapping of the committed rd.
REQ-009 SHALL have port free_preg, input, PW bits; the physical index being returned.
REQ-010 SHALL have port commit_alloc, input, 1 bit; a committed instruction made its allocated preg architectural.
REQ-011 SHALL have port flush, input, 1 bit; mispredict recovery.
REQ-012 SHALL have port empty, output, 1 bit; count == 0.
REQ-013 SHALL have port full, output, 1 bit; count == DEPTH.
REQ-014 SHALL have port count, output, PW+1 bits; the current number of free entries.
REQ-015 SHALL have port overflow_err, output, 1 bit; sticky, set on an illegal free.

Function
REQ-016 SHALL store DEPTH entries of PW bits in a circular buffer with head, tail and retire_head pointers, each in 0..DEPTH-1.
REQ-017 SHALL wrap every pointer from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-018 SHALL drive alloc_preg = mem[head] combinationally, with zero-cycle latency, and drive alloc_valid = !empty.
REQ-019 SHALL, on an accepted alloc (alloc_req && alloc_valid), advance head by 1 and decrement count.
REQ-020 SHALL ignore alloc_req while empty, leaving state unchanged; the upstream stage must stall.
REQ-021 SHALL, on an accepted free (free_req && !full && free_preg != 0), write mem[tail] = free_preg, advance tail and increment count.
REQ-022 SHALL ignore free_req with free_preg == 0, which is not an error; p0 is permanently bound to x0.
REQ-023 SHALL ignore free_req while full and set overflow_err.
REQ-024 SHALL keep count unchanged on a simultaneous accepted alloc and free, with both pointers advancing.
REQ-025 SHALL NOT bypass a freed preg to alloc_preg in the same cycle; it becomes allocatable on the next cycle at the earliest.
REQ-026 SHALL maintain retire_count: +1 per accepted free, -1 per commit_alloc, net 0 when both occur.
REQ-027 SHALL advance retire_head by 1 on each commit_alloc.
REQ-028 SHALL, on flush, set head = retire_head and count = retire_count, discarding speculative allocations.
REQ-029 SHALL give flush priority over alloc_req in the same cycle; that alloc is not performed.
REQ-030 SHALL apply commit_alloc and free_req presented in the same cycle as flush before the restore, so the restored head and count include them.
REQ-031 SHALL keep tail unchanged by flush.
REQ-032 SHALL define commit_alloc while retire_count == 0 as illegal, with state unchanged and overflow_err set.

Reset
REQ-033 SHALL, while rst == 0 at a clock edge, set mem[i] = 32 + i for i in 0..DEPTH-1.
REQ-034 SHALL, while rst == 0 at a clock edge, set head = 0, tail = 0 and retire_head = 0.
REQ-035 SHALL, while rst == 0 at a clock edge, set count = retire_count = DEPTH and clear overflow_err.
REQ-036 SHALL hold outputs after reset at alloc_valid = 1, alloc_preg = 32, full = 1, empty = 0, count = DEPTH.
REQ-037 SHALL abandon all in-flight operations when reset is asserted mid-operation; inputs sampled in reset cycles have no effect.

Verification
REQ-038 SHALL cover: reset, then alloc_req for 3 cycles -> alloc_preg 32, 33, 34; count 32 -> 29; full 1 -> 0.
REQ-039 SHALL cover: alloc 32 times (NUM_REGS = 64) -> empty = 1 and alloc_valid = 0; a further alloc_req leaves head and count unchanged.
REQ-040 SHALL cover: empty, then free_preg = 5 -> next cycle alloc_valid = 1 and alloc_preg = 5; alloc_valid stays 0 in the free cycle itself.
REQ-041 SHALL cover: full list with free_req, free_preg = 7 -> overflow_err = 1, count stays 32; also free_preg = 0 -> no change and no error.
REQ-042 SHALL cover: alloc 4, commit_alloc 1, free 1, then flush -> head = 1, count = 32, next alloc_preg = 33.
REQ-043 SHALL cover: simultaneous alloc and free with head at DEPTH-1 -> head wraps to 0, count unchanged, freed value readable after a full wrap.
